mux_rr_sel: RTL

Round-robin select generator that sits directly upstream of the 4:1 mux stage (`mux_4_1`). It arbitrates among four requesting channels and drives the mux `sel[1:0]` plus a valid/ready handshake toward the consumer of the mux output `y`. The granted channel may hold the mux for a bounded burst of consecutive beats before the grant rotates.

---
 rtl/mux_rr_sel.sv | 117 +++++++++++
 1 files changed

// File: rtl/mux_rr_sel.sv
// Round-robin select generator for a 4:1 mux with bounded per-grant bursts.
// Latency: sel/out_valid registered, 1 cycle from req to out_valid; gnt is combinational.
// Backpressure: while out_valid && !out_ready, sel, out_valid and the burst count all hold.
module mux_rr_sel #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       out_ready,
    output logic [1:0] sel,
    output logic       out_valid,
    output logic [3:0] gnt
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW:0] MAX_B = (CW + 1)'(MAX_BURST);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      sel_q, sel_d;
    logic [1:0]      ptr_q, ptr_d;
    logic            vld_q, vld_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic [2:0]      pick_idle;
    logic [2:0]      pick_rot;
    logic [CW:0]     cnt_inc;
    logic            take;

    // Returns {found, index}: first set bit of r in order p+1, p+2, p+3, p.
    function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [2:0] res;
        logic [1:0] c;
        res = 3'b000;
        // Walk from the farthest position down so the nearest hit wins.
        for (int i = 4; i >= 1; i--) begin
            c = p + 2'(i);
            if (r[c]) begin
                res = {1'b1, c};
            end
        end
        return res;
    endfunction

    assign pick_idle = rr_pick(req, ptr_q);
    assign pick_rot  = rr_pick(req, sel_q);
    assign cnt_inc   = {1'b0, cnt_q} + (CW + 1)'(1);
    assign take      = vld_q && out_ready;

    // Next-state: start a grant from idle, extend a burst, rotate, or fall back to idle.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        ptr_d   = ptr_q;
        vld_d   = vld_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                vld_d = 1'b0;
                if (|req) begin
                    sel_d   = pick_idle[1:0];
                    cnt_d   = '0;
                    vld_d   = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (take) begin
                    if (req[sel_q] && (cnt_inc < MAX_B)) begin
                        cnt_d = cnt_inc[CW-1:0];
                    end else if (pick_rot[2]) begin
                        // Rotation with no bubble; may re-grant a lone requester.
                        ptr_d = sel_q;
                        sel_d = pick_rot[1:0];
                        cnt_d = '0;
                    end else begin
                        ptr_d   = sel_q;
                        vld_d   = 1'b0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                vld_d   = 1'b0;
            end
        endcase
    end

    // State registers; ptr resets to 3 so the first search starts at channel 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            ptr_q   <= 2'd3;
            vld_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            ptr_q   <= ptr_d;
            vld_q   <= vld_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sel       = sel_q;
    assign out_valid = vld_q;
    assign gnt       = take ? (4'b0001 << sel_q) : 4'b0000;

endmodule
